// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: the instruction-memory request/response pair, the redirect path and the decode handshake.
// The misalignment status signals exist only when FETCH_MISALIGN_CHK_EN is defined.
interface fetch_unit_if;
    logic [31:0] o_pc;
    logic        o_pc_req;
    logic [31:0] i_instr;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_instr;
    logic        i_id_ready;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        o_misalign;
    logic [31:0] o_misalign_pc;
`endif

    modport master (
`ifdef FETCH_MISALIGN_CHK_EN
        output o_misalign, o_misalign_pc,
`endif
        output o_pc, o_pc_req, o_id_valid, o_id_pc, o_id_instr,
        input  i_instr, i_redirect, i_redirect_pc, i_id_ready
    );

    modport slave (
`ifdef FETCH_MISALIGN_CHK_EN
        input  o_misalign, o_misalign_pc,
`endif
        input  o_pc, o_pc_req, o_id_valid, o_id_pc, o_id_instr,
        output i_instr, i_redirect, i_redirect_pc, i_id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, 1-cycle memory requests, {pc, instr} queue to decode, redirects.
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirects halt fetch and report the offending PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {RUN, HALT} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              inflight_v_q, inflight_v_d;
    logic [31:0]       inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [31:0]       fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]       fifo_instr_q [FIFO_DEPTH];

    logic              id_valid, pop, push, issue;
    logic [PTR_W:0]    occupancy;
`ifdef FETCH_MISALIGN_CHK_EN
    logic              misalign_q, misalign_d;
    logic [31:0]       misalign_pc_q, misalign_pc_d;
    logic              redirect_misaligned;
`endif

    assign id_valid  = (count_q != '0) && !bus.i_redirect;
    assign pop       = id_valid && bus.i_id_ready;
    // Entries already held or still arriving, after this cycle's pop, must leave a slot for a new request.
    assign occupancy = count_q + (PTR_W+1)'(inflight_v_q) - (PTR_W+1)'(pop);
    assign issue     = (state_q == RUN) && !i_rst && !bus.i_redirect
                       && (occupancy < (PTR_W+1)'(FIFO_DEPTH));
    assign push      = inflight_v_q && !bus.i_redirect;

    assign bus.o_pc       = pc_q;
    assign bus.o_pc_req   = issue;
    assign bus.o_id_valid = id_valid;
    assign bus.o_id_pc    = fifo_pc_q[rd_ptr_q];
    assign bus.o_id_instr = fifo_instr_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_misaligned = bus.i_redirect_pc[1:0] != 2'b00;
    assign bus.o_misalign      = misalign_q;
    assign bus.o_misalign_pc   = misalign_pc_q;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_v_d  = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d    = misalign_q;
        misalign_pc_d = misalign_pc_q;
`endif
        if (bus.i_redirect) begin
            pc_d     = bus.i_redirect_pc & ~32'h3;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = RUN;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_d = redirect_misaligned;
            if (redirect_misaligned) begin
                state_d       = HALT;
                misalign_pc_d = bus.i_redirect_pc;
            end
`endif
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_v_d  = 1'b1;
                inflight_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            // NOTE: the queue storage is reset because the head entry is visible on the outputs right after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
                fifo_instr_q[wr_ptr_q] <= bus.i_instr;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q    <= misalign_d;
            misalign_pc_q <= misalign_pc_d;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stimulus, every cycle checked against a queue-based model.
// Honours FETCH_MISALIGN_CHK_EN when defined.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clk = 1'b0;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: fetch pointer, queue of {pc, instr}, one outstanding request.
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_halt;
    bit          m_mis;
    logic [31:0] m_mis_pc;
    bit          known   = 1'b0;
    logic [31:0] last_pc = '0;

    logic [31:0] s_pc, s_idpc, s_idinstr;
    logic        s_req, s_valid;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        s_mis;
    logic [31:0] s_mis_pc;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // One clock cycle: drive at the falling edge, compare against the model, then advance the model.
    task automatic cycle(input logic r, input logic redir, input logic [31:0] rpc, input logic rdy);
        bit pop     = 1'b0;
        bit exp_req = 1'b0;
        @(negedge clk);
        rst               = r;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        bus.i_id_ready    = rdy;
        bus.i_instr       = instr_of(last_pc);
        #1;
        s_pc      = bus.o_pc;
        s_req     = bus.o_pc_req;
        s_valid   = bus.o_id_valid;
        s_idpc    = bus.o_id_pc;
        s_idinstr = bus.o_id_instr;
`ifdef FETCH_MISALIGN_CHK_EN
        s_mis     = bus.o_misalign;
        s_mis_pc  = bus.o_misalign_pc;
`endif
        if (known) begin
            pop     = (m_q.size() != 0) && !redir && rdy;
            exp_req = !m_halt && !r && !redir
                      && ((m_q.size() + int'(m_pend) - int'(pop)) < DEPTH);
            check("o_pc", s_pc, m_pc);
            check("o_pc_req", 32'(s_req), 32'(exp_req));
            check("o_id_valid", 32'(s_valid), 32'((m_q.size() != 0) && !redir));
            if ((m_q.size() != 0) && !redir) begin
                check("o_id_pc", s_idpc, m_q[0][63:32]);
                check("o_id_instr", s_idinstr, m_q[0][31:0]);
            end
`ifdef FETCH_MISALIGN_CHK_EN
            check("o_misalign", 32'(s_mis), 32'(m_mis));
            check("o_misalign_pc", s_mis_pc, m_mis_pc);
`endif
        end

        if (r) begin
            m_pc     = RESET_PC;
            m_q.delete();
            m_pend   = 1'b0;
            m_halt   = 1'b0;
            m_mis    = 1'b0;
            m_mis_pc = '0;
            known    = 1'b1;
        end else if (known) begin
            if (redir) begin
                m_q.delete();
                m_pend = 1'b0;
                m_pc   = rpc & ~32'h3;
`ifdef FETCH_MISALIGN_CHK_EN
                if (rpc[1:0] != 2'b00) begin
                    m_halt   = 1'b1;
                    m_mis    = 1'b1;
                    m_mis_pc = rpc;
                end else begin
                    m_halt = 1'b0;
                    m_mis  = 1'b0;
                end
`endif
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_pend) m_q.push_back({m_pend_pc, instr_of(m_pend_pc)});
                if (exp_req) begin
                    m_pend    = 1'b1;
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
        last_pc = s_pc;
    endtask

    initial begin
        int          n;
        int          k;
        logic        r_r, r_rd, r_rdy;
        logic [31:0] r_pc;

        rst               = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_id_ready    = 1'b0;
        bus.i_instr       = '0;

        // Reset, then linear fetch
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check("lin_pc0", s_pc, 32'h0);
        check("lin_req0", 32'(s_req), 32'd1);
        check("lin_valid0", 32'(s_valid), 32'd0);
        check("rst_id_pc", s_idpc, 32'h0);
        check("rst_id_instr", s_idinstr, 32'h0);
        cycle(0, 0, 0, 1);
        check("lin_pc1", s_pc, 32'h4);
        cycle(0, 0, 0, 1);
        check("lin_valid2", 32'(s_valid), 32'd1);
        check("lin_idpc2", s_idpc, 32'h0);
        check("lin_instr2", s_idinstr, instr_of(32'h0));
        repeat (5) cycle(0, 0, 0, 1);

        // Backpressure
        cycle(1, 0, 0, 0);
        n = 0;
        repeat (6) begin
            cycle(0, 0, 0, 0);
            n += int'(s_req);
        end
        check("bp_reqs", n, DEPTH);
        check("bp_pc_hold", s_pc, 32'(4 * DEPTH));
        check("bp_req_off", 32'(s_req), 32'd0);
        cycle(0, 0, 0, 1);
        check("bp_first_pop", s_idpc, 32'h0);
        repeat (5) cycle(0, 0, 0, 1);

        // Redirect while streaming
        cycle(0, 1, 32'h100, 1);
        check("rd_valid_r0", 32'(s_valid), 32'd0);
        cycle(0, 0, 0, 1);
        check("rd_valid_r1", 32'(s_valid), 32'd0);
        check("rd_pc_r1", s_pc, 32'h100);
        check("rd_req_r1", 32'(s_req), 32'd1);
        cycle(0, 0, 0, 1);
        check("rd_valid_r2", 32'(s_valid), 32'd0);
        cycle(0, 0, 0, 1);
        check("rd_valid_r3", 32'(s_valid), 32'd1);
        check("rd_idpc_r3", s_idpc, 32'h100);
        repeat (4) cycle(0, 0, 0, 1);

        // Redirect plus ready with the queue full
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h100, 1);
        k = 0;
        do begin
            cycle(0, 0, 0, 1);
            k++;
        end while (!s_valid && k < 8);
        check("full_rd_lat", k, 3);
        check("full_rd_pc", s_idpc, 32'h100);

        // Unaligned target is aligned down
        cycle(0, 1, 32'h202, 1);
        cycle(0, 0, 0, 1);
        check("align_pc", s_pc, 32'h200);
`ifndef FETCH_MISALIGN_CHK_EN
        check("align_req", 32'(s_req), 32'd1);
`endif

        // PC wrap
        cycle(0, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 0, 0, 1);
        check("wrap_pc0", s_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1);
        check("wrap_pc1", s_pc, 32'h0);
        cycle(0, 0, 0, 1);
        check("wrap_pc2", s_pc, 32'h4);

        // Reset with the queue full
        repeat (4) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("mid_rst_valid", 32'(s_valid), 32'd0);
        check("mid_rst_pc", s_pc, RESET_PC);
        repeat (4) cycle(0, 0, 0, 1);

`ifdef FETCH_MISALIGN_CHK_EN
        // Misaligned redirect halts fetch until an aligned redirect
        cycle(0, 1, 32'h102, 1);
        n = 0;
        repeat (10) begin
            cycle(0, 0, 0, 1);
            n += int'(s_req);
        end
        check("mis_no_req", n, 0);
        check("mis_flag", 32'(s_mis), 32'd1);
        check("mis_pc", s_mis_pc, 32'h102);
        cycle(0, 1, 32'h200, 1);
        cycle(0, 0, 0, 1);
        check("mis_clear", 32'(s_mis), 32'd0);
        check("mis_resume_pc", s_pc, 32'h200);
        check("mis_resume_req", 32'(s_req), 32'd1);
`endif

        // Random traffic
        repeat (3000) begin
            r_r   = ($urandom_range(0, 99) < 1);
            r_rd  = ($urandom_range(0, 99) < 6);
            r_pc  = $urandom;
            if ($urandom_range(0, 99) < 80) r_pc[1:0] = 2'b00;
            r_rdy = ($urandom_range(0, 99) < 65);
            cycle(r_r, r_rd, r_pc, r_rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of instruction_memory. It generates the PC and read requests and captures the returned instructions into a small FIFO together with their PCs. It presents {pc, instr} to decode through a valid/ready handshake and handles redirects from branches and jumps. Memory read latency is fixed at 1 cycle: an address driven in cycle N returns its instruction on i_instr in cycle N+1.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction queue entries; must be a power of two and at least 2

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  synchronous reset, active-high
o_pc  out  32  fetch address to instruction_memory i_pc
o_pc_req  out  1  fetch issued this cycle; the response is captured next cycle
i_instr  in  32  instruction_memory o_instr
i_redirect  in  1  flush and restart fetch
i_redirect_pc  in  32  restart address
o_id_valid  out  1  head entry valid to decode
o_id_pc  out  32  PC of the head entry
o_id_instr  out  32  instruction of the head entry
i_id_ready  in  1  decode accepts the head entry

Behaviour:
- Reset (i_rst=1 at an edge):
  - pc_q=RESET_PC; FIFO is emptied; inflight_v=0; state=RUN.
  - Outputs: o_pc_req=0, o_id_valid=0, o_pc=RESET_PC, o_id_pc=0, o_id_instr=0.
  - Reset mid-operation discards any in-flight response.
- pop = o_id_valid & i_id_ready.
- Issue: o_pc=pc_q. o_pc_req=1 when all of the following hold: state=RUN, !i_rst, !i_redirect, and (count + inflight_v - pop) < FIFO_DEPTH.
  - On issue: pc_q += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0). inflight_v<=1 and inflight_pc<=pc_q.
  - No issue: pc_q holds and inflight_v<=0.
- Capture: if inflight_v=1 and no redirect this cycle, push {inflight_pc, i_instr}. The FIFO never overflows because of the credit rule.
- Output: o_id_valid = (count!=0) & !i_redirect. o_id_pc and o_id_instr come from the head entry and hold while not popped.
- Latency: request in cycle N -> entry pushed at end of N+1 -> o_id_valid in N+2. Streaming throughput with i_id_ready=1 is 1 instr/cycle.
- Simultaneous push and pop: count is unchanged, and data ordering is preserved.
- Redirect (i_redirect=1 in cycle R):
  - Outranks every other event. The FIFO is flushed and the in-flight response is dropped.
  - Any pop in cycle R is ignored. No issue occurs in R.
  - pc_q<=i_redirect_pc with bits[1:0] cleared.
  - R+1 issues the target address; o_id_valid first rises in R+3.
  - Back-to-back redirects: the last one wins.
- FSM: RUN, HALT. HALT is reachable only with the optional feature. In HALT: no issue, the FIFO drains normally, and only a redirect or reset leaves it.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined: adds outputs o_misalign (1 bit) and o_misalign_pc (32 bits).
  - A redirect with i_redirect_pc[1:0]!=0 flushes as normal and then enters HALT.
  - o_misalign<=1 and o_misalign_pc<=i_redirect_pc, both held.
  - An aligned redirect clears o_misalign and returns to RUN. Reset clears both outputs.
- Undefined: the ports are absent, bits[1:0] are silently cleared, and the FSM stays in RUN.

Test Plan:
- Linear fetch: reset for 2 cycles, then i_id_ready=1 -> o_pc sequence 0,4,8,12,... with one o_pc_req per cycle. The first o_id_valid arrives 2 cycles after the first request, and o_id_pc tracks 0,4,8 with matching instructions.
- Backpressure: i_id_ready=0 for 6 cycles -> exactly FIFO_DEPTH requests (PC 0,4), then o_pc_req=0 and o_pc holds 8. On ready=1, entries pop in order 0,4,8 with no gap or duplicate.
- Redirect: while streaming, i_redirect=1 with i_redirect_pc=0x100 in cycle R -> o_id_valid=0 in R, R+1 and R+2. o_pc=0x100 with a request in R+1, and o_id_pc=0x100 in R+3. No stale PC appears afterwards.
- Redirect plus ready in the same cycle with the FIFO full -> the pop is ignored and the next valid entry is 0x100. A redirect to 0x202 without the macro fetches 0x200.
- Wrap and mid-op reset: a redirect to 0xFFFF_FFFC is followed by fetches at 0x0 and 0x4. Asserting i_rst while the FIFO is full -> the next cycle has o_id_valid=0 and o_pc=RESET_PC, and the old in-flight response is never output.
- With FETCH_MISALIGN_CHK_EN: a redirect to 0x102 -> o_misalign=1, o_misalign_pc=0x102, and no o_pc_req for 10 cycles. A redirect to 0x200 then clears o_misalign and fetch resumes at 0x200.
